hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage vector pipeline. It extends plain M/W forwarding with three things: load-use stall detection, branch flush generation, and a counter-driven freeze of F/D/E while a multi-cycle vector op occupies Execute. Two saturating performance counters report stall and flush cycles. It sits beside the stage modules in the pipeline top and drives their stall/flush enables and the Execute forwarding selects.

## Interface
Parameters:
- REG_ADDR_W, 6, register address width; address 0 is the zero register and never creates a hazard
- N_SRC, 2, source operands per instruction
- VEC_LAT, 4, total cycles a vector op occupies Execute (≥1)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; asynchronous, active-low
- RS_D  in  N_SRC*REG_ADDR_W  Decode source addresses; operand i is at bits [i*REG_ADDR_W +: REG_ADDR_W]
- RS_E  in  N_SRC*REG_ADDR_W  Execute source addresses, same packing
- RD_E, RD_M, RD_W  in  REG_ADDR_W  destination addresses in the E, M and W stages
- RegWriteE, RegWriteM, RegWriteW  in  1  register write enables in the E, M and W stages
- ResultSrcE  in  1  1 = instruction in Execute is a load
- PCSrcE  in  1  branch/jump taken in Execute
- VecStartE  in  1  vector multi-cycle op present in Execute
- clr_counts  in  1  synchronous clear of both counters
- Forward_E  out  2*N_SRC  per-source forwarding select: 00 register file, 01 ResultW, 10 ALU_ResultM
- StallF, StallD, StallE  out  1  hold the F, D and E pipeline registers
- FlushD, FlushE, FlushM  out  1  insert a bubble into D, E or M
- vec_busy  out  1  FSM is in BUSY
- stall_count, flush_count  out  CNT_W  performance counters

## Operation
Forwarding (combinational), evaluated per source i:
- Select 10 when RegWriteM=1, RD_M≠0 and RD_M==RS_E[i].
- Otherwise select 01 when RegWriteW=1, RD_W≠0 and RD_W==RS_E[i].
- Otherwise select 00.
- M has priority over W.

FSM with states IDLE and BUSY, plus a down-counter vcnt of width $clog2(VEC_LAT).

vec_stall condition:
- In IDLE: VecStartE=1 and VEC_LAT>1.
- In BUSY: vcnt≠0.

When vec_stall=1:
- StallF=StallD=StallE=1 and FlushM=1.
- Load-use and branch logic are suppressed.

FSM transitions:
- IDLE with vec_stall → BUSY, vcnt←VEC_LAT-2.
- BUSY with vcnt≠0 → vcnt decrements.
- BUSY with vcnt==0 → IDLE. This is the release cycle: no stall outputs, and the op advances into M.
- VecStartE is ignored while in BUSY.
- VEC_LAT=1: never enters BUSY, no stall.
- Execute latches vector operands on the IDLE/VecStartE cycle. Forwarding selects later in the op are not relied upon.

Load-use hazard (IDLE, no vec_stall):
- Triggers when ResultSrcE=1, RegWriteE=1, RD_E≠0 and RD_E matches any RS_D[i].
- Response: StallF=StallD=1, FlushE=1, for one cycle.

Branch (IDLE, no vec_stall): PCSrcE=1 → FlushD=FlushE=1.

Simultaneous load-use and branch: the branch wins. FlushD=FlushE=1 and StallF=StallD=0, because the Decode instruction is wrong-path.

Counters:
- stall_count +1 on every cycle with StallF=1.
- flush_count +1 on every cycle with a branch flush.
- Both saturate at all-ones.
- clr_counts zeroes both and takes priority over increment.

## Timing
- Reset (rst=0): state IDLE, vcnt=0, both counters 0. All stall/flush outputs, vec_busy and Forward_E are forced 0 while rst=0.
- Reset asserted mid-BUSY returns to IDLE immediately (asynchronously).
- Forward_E, stall and flush outputs are combinational from inputs and state: zero-cycle latency.
- A vector op stalls F/D/E for exactly VEC_LAT-1 cycles and spends VEC_LAT cycles in E.
- vec_busy is high for VEC_LAT-1 cycles, starting the cycle after VecStartE.
- Counters are registered and visible the cycle after the event.

## Structure
- hazard_pkg holds:
  - typedef enum logic [1:0] fwd_sel_e {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}
  - typedef enum logic {IDLE, BUSY} hz_state_e
  - localparam ZERO_REG=0
- Sub-module fwd_sel: one source address plus the M/W destinations and write enables in, fwd_sel_e out. Instantiated N_SRC times in a generate loop.

## Test plan
- RS_E[0]=5, RD_M=5/RegWriteM=1, RD_W=5/RegWriteW=1 → Forward_E[1:0]=10. Then drop RegWriteM → 01. Then set RS_E[0]=0 with matching RD → 00.
- Load in E with RD_E=7, RS_D[1]=7 → StallF=StallD=FlushE=1 for one cycle. stall_count goes 0→1.
- Same load-use setup with PCSrcE=1 → FlushD=FlushE=1, StallF=StallD=0. flush_count +1.
- VEC_LAT=4, VecStartE held high for 4 cycles → stall on cycles 0–2, release on cycle 3. vec_busy high on cycles 1–3. stall_count=3.
- rst pulsed low in the second BUSY cycle → all outputs 0 immediately, state IDLE, counters 0. After release, a new VecStartE restarts the full 3-cycle stall.
- Force stall_count to all-ones with CNT_W=4 → it holds at 15. clr_counts together with a stall → reads 0 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the vector-pipeline hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE,
    BUSY
  } hz_state_e;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one Execute source operand; Memory stage beats Writeback.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 6
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  output fwd_sel_e              sel
);

  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

  always_comb begin
    // NOTE: assign a default first so every path drives sel and no latch is inferred.
    sel = FWD_RF;
    if (reg_write_m && (rd_m != ZERO) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != ZERO) && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline control: forwarding, load-use stall, branch flush,
// multi-cycle vector freeze and saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 6,
  parameter int N_SRC      = 2,
  parameter int VEC_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC*REG_ADDR_W-1:0] RS_D,
  input  logic [N_SRC*REG_ADDR_W-1:0] RS_E,
  input  logic [REG_ADDR_W-1:0]       RD_E,
  input  logic [REG_ADDR_W-1:0]       RD_M,
  input  logic [REG_ADDR_W-1:0]       RD_W,
  input  logic                        RegWriteE,
  input  logic                        RegWriteM,
  input  logic                        RegWriteW,
  input  logic                        ResultSrcE,
  input  logic                        PCSrcE,
  input  logic                        VecStartE,
  input  logic                        clr_counts,
  output logic [2*N_SRC-1:0]          Forward_E,
  output logic                        StallF,
  output logic                        StallD,
  output logic                        StallE,
  output logic                        FlushD,
  output logic                        FlushE,
  output logic                        FlushM,
  output logic                        vec_busy,
  output logic [CNT_W-1:0]            stall_count,
  output logic [CNT_W-1:0]            flush_count
);

  localparam int VCNT_W = (VEC_LAT > 2) ? $clog2(VEC_LAT) : 1;
  localparam logic [VCNT_W-1:0] VCNT_LOAD = VCNT_W'((VEC_LAT > 1) ? VEC_LAT - 2 : 0);
  localparam bit VEC_MULTI = (VEC_LAT > 1);
  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

  hz_state_e         state, state_n;
  logic [VCNT_W-1:0] vcnt, vcnt_n;

  logic [2*N_SRC-1:0] fwd_raw;
  logic vec_stall, hazard_en, rs_match, load_use, lu_stall, branch;
  logic stall_fd, stall_e, flush_d, flush_e, flush_m;

  for (genvar i = 0; i < N_SRC; i++) begin : g_fwd
    fwd_sel_e sel;
    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_sel (
      .rs          (RS_E[i*REG_ADDR_W +: REG_ADDR_W]),
      .rd_m        (RD_M),
      .rd_w        (RD_W),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .sel         (sel)
    );
    assign fwd_raw[2*i +: 2] = sel;
  end

  always_comb begin
    rs_match = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (RS_D[i*REG_ADDR_W +: REG_ADDR_W] == RD_E) rs_match = 1'b1;
    end
    load_use = ResultSrcE && RegWriteE && (RD_E != ZERO) && rs_match;

    vec_stall = (state == IDLE) ? (VecStartE && VEC_MULTI) : (vcnt != '0);
    // Hazard logic only runs in IDLE outside a freeze; the release cycle is quiet too.
    hazard_en = (state == IDLE) && !vec_stall;
    branch    = hazard_en && PCSrcE;
    lu_stall  = hazard_en && load_use && !PCSrcE;

    stall_fd = vec_stall || lu_stall;
    stall_e  = vec_stall;
    flush_d  = branch;
    flush_e  = branch || lu_stall;
    flush_m  = vec_stall;

    state_n = state;
    vcnt_n  = vcnt;
    if (state == IDLE) begin
      if (vec_stall) begin
        state_n = BUSY;
        vcnt_n  = VCNT_LOAD;
      end
    end else if (vcnt != '0) begin
      vcnt_n = vcnt - VCNT_W'(1);
    end else begin
      state_n = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      vcnt  <= '0;
    end else begin
      state <= state_n;
      vcnt  <= vcnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (clr_counts) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_fd && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (branch && (flush_count != '1))   flush_count <= flush_count + CNT_W'(1);
    end
  end

  // Outputs are held low for the whole reset window, even with live hazard inputs.
  assign Forward_E = rst ? fwd_raw : '0;
  assign StallF    = rst && stall_fd;
  assign StallD    = rst && stall_fd;
  assign StallE    = rst && stall_e;
  assign FlushD    = rst && flush_d;
  assign FlushE    = rst && flush_e;
  assign FlushM    = rst && flush_m;
  assign vec_busy  = rst && (state == BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (VEC_LAT=4, CNT_W=4 so saturation is reachable).
module tb_hazard_ctrl;

  localparam int AW = 6;
  localparam int NS = 2;
  localparam int VL = 4;
  localparam int CW = 4;

  // Control vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, vec_busy}
  localparam logic [6:0] C_NONE = 7'b000_000_0;
  localparam logic [6:0] C_LU   = 7'b110_010_0;
  localparam logic [6:0] C_BR   = 7'b000_110_0;
  localparam logic [6:0] C_VEC  = 7'b111_001_0;
  localparam logic [6:0] C_VECB = 7'b111_001_1;
  localparam logic [6:0] C_REL  = 7'b000_000_1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NS*AW-1:0] RS_D, RS_E;
  logic [AW-1:0] RD_E, RD_M, RD_W;
  logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, VecStartE, clr_counts;
  logic [2*NS-1:0] Forward_E;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, vec_busy;
  logic [CW-1:0] stall_count, flush_count;

  typedef struct {
    logic [2*NS-1:0] fwd;
    logic [6:0]      ctl;
    logic [CW-1:0]   sc;
    logic [CW-1:0]   fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  hazard_ctrl #(.REG_ADDR_W(AW), .N_SRC(NS), .VEC_LAT(VL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .RS_D(RS_D), .RS_E(RS_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .VecStartE(VecStartE),
    .clr_counts(clr_counts), .Forward_E(Forward_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .vec_busy(vec_busy), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  wire [6:0] ctl_obs = {StallF, StallD, StallE, FlushD, FlushE, FlushM, vec_busy};

  // Scoreboard consumer: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (ctl_obs !== e.ctl) begin
        failures++;
        $display("FAIL ctl t=%0t actual=%b required=%b", $time, ctl_obs, e.ctl);
      end
      checks++;
      if (Forward_E !== e.fwd) begin
        failures++;
        $display("FAIL forward t=%0t actual=%b required=%b", $time, Forward_E, e.fwd);
      end
      checks++;
      if ({stall_count, flush_count} !== {e.sc, e.fc}) begin
        failures++;
        $display("FAIL counters t=%0t actual=%0d/%0d required=%0d/%0d",
                 $time, stall_count, flush_count, e.sc, e.fc);
      end
    end
  end

  // Push expectations for the current cycle, then advance the counter model.
  task automatic step(input logic [2*NS-1:0] fwd, input logic [6:0] ctl);
    exp_t e;
    e.fwd = fwd;
    e.ctl = ctl;
    e.sc  = m_stall;
    e.fc  = m_flush;
    sb.push_back(e);
    @(negedge clk);
    if (clr_counts) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (ctl[6] && (m_stall != '1)) m_stall = m_stall + 1'b1;
      if (ctl[3] && (m_flush != '1)) m_flush = m_flush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RS_D = '0; RS_E = '0; RD_E = '0; RD_M = '0; RD_W = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 1'b0; PCSrcE = 1'b0; VecStartE = 1'b0; clr_counts = 1'b0;
  endtask

  task automatic set_load_use();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 6'd7; RS_D = {6'd7, 6'd3};
  endtask

  task automatic test_reset();
    idle_inputs();
    set_load_use();
    PCSrcE = 1'b1; VecStartE = 1'b1;
    RS_E = {6'd0, 6'd5}; RD_M = 6'd5; RegWriteM = 1'b1;
    #12;
    checks++;
    if (ctl_obs !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl actual=%b required=%b", ctl_obs, 7'b0);
    end
    checks++;
    if (Forward_E !== '0 || stall_count !== '0 || flush_count !== '0) begin
      failures++;
      $display("FAIL reset_fwd_cnt actual=%b/%0d/%0d required=0/0/0",
               Forward_E, stall_count, flush_count);
    end
    idle_inputs();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    step(4'b0000, C_NONE);
  endtask

  task automatic test_forwarding();
    RS_E = {6'd0, 6'd5}; RD_M = 6'd5; RegWriteM = 1'b1; RD_W = 6'd5; RegWriteW = 1'b1;
    step(4'b0010, C_NONE);
    RegWriteM = 1'b0;
    step(4'b0001, C_NONE);
    RS_E = {6'd0, 6'd0}; RD_M = 6'd0; RD_W = 6'd0; RegWriteM = 1'b1;
    step(4'b0000, C_NONE);
    RS_E = {6'd9, 6'd5}; RD_M = 6'd9; RD_W = 6'd5;
    step(4'b1001, C_NONE);
    idle_inputs();
  endtask

  task automatic test_load_use();
    set_load_use();
    step(4'b0000, C_LU);
    idle_inputs();
    step(4'b0000, C_NONE);
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 6'd0; RS_D = '0;
    step(4'b0000, C_NONE);
    set_load_use();
    ResultSrcE = 1'b0;
    step(4'b0000, C_NONE);
    idle_inputs();
  endtask

  task automatic test_branch_priority();
    set_load_use();
    PCSrcE = 1'b1;
    step(4'b0000, C_BR);
    idle_inputs();
    PCSrcE = 1'b1;
    step(4'b0000, C_BR);
    idle_inputs();
    step(4'b0000, C_NONE);
  endtask

  task automatic test_vector();
    VecStartE = 1'b1;
    step(4'b0000, C_VEC);
    set_load_use();
    step(4'b0000, C_VECB);
    ResultSrcE = 1'b0; RegWriteE = 1'b0; PCSrcE = 1'b1;
    step(4'b0000, C_VECB);
    PCSrcE = 1'b0;
    step(4'b0000, C_REL);
    idle_inputs();
    step(4'b0000, C_NONE);
  endtask

  task automatic test_reset_mid_busy();
    VecStartE = 1'b1;
    step(4'b0000, C_VEC);
    step(4'b0000, C_VECB);
    checks++;
    if (StallF !== 1'b1 || vec_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_before_reset actual=%b%b required=11", StallF, vec_busy);
    end
    RS_E = {6'd0, 6'd5}; RD_M = 6'd5; RegWriteM = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (ctl_obs !== 7'b0 || Forward_E !== '0) begin
      failures++;
      $display("FAIL async_reset_out actual=%b/%b required=0/0", ctl_obs, Forward_E);
    end
    checks++;
    if (stall_count !== '0 || flush_count !== '0) begin
      failures++;
      $display("FAIL async_reset_cnt actual=%0d/%0d required=0/0", stall_count, flush_count);
    end
    m_stall = '0;
    m_flush = '0;
    idle_inputs();
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (vec_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset actual=%b required=0", vec_busy);
    end
    VecStartE = 1'b1;
    step(4'b0000, C_VEC);
    step(4'b0000, C_VECB);
    step(4'b0000, C_VECB);
    step(4'b0000, C_REL);
    idle_inputs();
    step(4'b0000, C_NONE);
  endtask

  task automatic test_saturation();
    PCSrcE = 1'b1;
    step(4'b0000, C_BR);
    idle_inputs();
    set_load_use();
    repeat (18) step(4'b0000, C_LU);
    clr_counts = 1'b1;
    step(4'b0000, C_LU);
    idle_inputs();
    step(4'b0000, C_NONE);
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_vector();
    test_reset_mid_busy();
    test_saturation();
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
